pitch_tone_synth: RTL

// - Inverse of the pitch-detect path: takes an FFT bin index on a dstream and emits a paced stream of

---
 rtl/pitch_synth_pkg.sv | 19 +
 rtl/pitch_tone_synth_if.sv | 11 +
 rtl/sine_quarter_lut.sv | 26 ++
 rtl/pitch_tone_synth.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/pitch_synth_pkg.sv
// rtl/pitch_synth_pkg.sv - shared types, table depth and quarter-wave entry function for the tone synthesiser
package pitch_synth_pkg;

    localparam int NSAMPLES_DEF = 1024;
    localparam int BIN_W_DEF    = $clog2(NSAMPLES_DEF);
    localparam int QLUT_DEPTH   = NSAMPLES_DEF / 4;

    typedef logic signed [15:0]    sample_t;
    typedef logic [BIN_W_DEF-1:0]  bin_t;
    typedef logic [15:0]           phase_t;

    // Half-index offset keeps the table free of exact zeros and makes the quadrant mirror exact.
    function automatic logic [14:0] qsine(int k, int nsamples);
        real a;
        a = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / real'(nsamples);
        return 15'($rtoi(32767.0 * $sin(a) + 0.5));
    endfunction

endpackage

// File: rtl/pitch_tone_synth_if.sv
// rtl/pitch_tone_synth_if.sv - valid/ready/data stream used for the bin input and sample output
interface pitch_tone_synth_if #(
    parameter int N = 16
);
    logic         valid;
    logic         ready;
    logic [N-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sine_quarter_lut.sv
// rtl/sine_quarter_lut.sv - quarter-wave sine magnitude ROM with one-cycle registered read
module sine_quarter_lut
    import pitch_synth_pkg::*;
#(
    parameter int NSAMPLES = 1024,
    parameter int AW       = $clog2(NSAMPLES) - 2
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    output logic [14:0]   mag
);

    logic [14:0] rom [NSAMPLES/4];

    for (genvar a = 0; a < NSAMPLES / 4; a++) begin : g_rom
        assign rom[a] = qsine(a, NSAMPLES);
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mag <= rom[addr];
        end
    end

endmodule

// File: rtl/pitch_tone_synth.sv
// rtl/pitch_tone_synth.sv - phase-accumulator sine synthesiser paced by a sample tick
// Optional PITCH_SYNTH_FADE_EN adds a gain ramp after bin changes (one extra cycle of latency).
module pitch_tone_synth
    import pitch_synth_pkg::*;
#(
    parameter int W          = 16,
    parameter int NSAMPLES   = 1024,
    parameter int BIN_W      = $clog2(NSAMPLES),
    parameter int PHASE_W    = 16,
    parameter int SAMPLE_DIV = 417
) (
    input  logic               clk,
    input  logic               reset,
    pitch_tone_synth_if.slave  pitch_input,
    pitch_tone_synth_if.master audio_output,
    output logic [15:0]        overrun_count
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);

    logic [CNT_W-1:0]   cnt;
    logic               tick;
    logic               rdy;
    logic               accept;
    logic [BIN_W-1:0]   cur_bin;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] inc;
    logic               p1;
    logic               mute_p;
    logic               zero_q;
    logic               neg_q;
    logic [BIN_W-1:0]   idx;
    logic [BIN_W-3:0]   k;
    logic [BIN_W-3:0]   addr;
    logic [14:0]        mag;
    logic signed [W-1:0] mag_s;
    logic signed [W-1:0] lut_s;
    logic               land;
    logic               valid_q;
    logic [15:0]        ovr_cnt;

    assign tick   = (cnt == CNT_W'(SAMPLE_DIV - 1));
    assign accept = pitch_input.valid && rdy;
    assign inc    = PHASE_W'(cur_bin) << (PHASE_W - BIN_W);

    // Quadrant fold: q[0] mirrors the table address, q[1] negates the magnitude.
    assign idx  = phase[PHASE_W-1 -: BIN_W];
    assign k    = idx[BIN_W-3:0];
    assign addr = idx[BIN_W-2] ? ~k : k;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            rdy     <= 1'b0;
            cur_bin <= '0;
            phase   <= '0;
            p1      <= 1'b0;
            mute_p  <= 1'b0;
            zero_q  <= 1'b1;
            neg_q   <= 1'b0;
        end else begin
            rdy <= 1'b1;
            cnt <= tick ? '0 : cnt + CNT_W'(1);
            if (accept) begin
                cur_bin <= pitch_input.data;
            end
            p1 <= tick;
            if (tick) begin
                phase  <= (cur_bin == '0) ? '0 : phase + inc;
                mute_p <= (cur_bin == '0);
            end
            if (p1) begin
                zero_q <= mute_p;
                neg_q  <= idx[BIN_W-1];
            end
        end
    end

    sine_quarter_lut #(
        .NSAMPLES (NSAMPLES),
        .AW       (BIN_W - 2)
    ) u_lut (
        .clk  (clk),
        .en   (p1),
        .addr (addr),
        .mag  (mag)
    );

    assign mag_s = W'(mag);
    assign lut_s = zero_q ? '0 : (neg_q ? -mag_s : mag_s);

`ifdef PITCH_SYNTH_FADE_EN
    logic [7:0]            gain;
    logic                  p2;
    logic signed [W-1:0]   out_q;
    logic signed [9:0]     gain_m;
    logic signed [W+9:0]   prod;

    assign gain_m = signed'({2'b00, gain}) + 10'sd1;
    assign prod   = lut_s * gain_m;

    always_ff @(posedge clk) begin
        if (reset) begin
            gain  <= '0;
            p2    <= 1'b0;
            out_q <= '0;
        end else begin
            p2 <= p1;
            if (accept && pitch_input.data != cur_bin) begin
                gain <= '0;
            end else if (tick && gain != 8'hFF) begin
                gain <= gain + 8'd1;
            end
            if (p2) begin
                out_q <= W'(prod >>> 8);
            end
        end
    end

    assign land              = p2;
    assign audio_output.data = out_q;
`else
    assign land              = p1;
    assign audio_output.data = lut_s;
`endif

    // A landing sample always wins; an unconsumed predecessor is counted as lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ovr_cnt <= '0;
        end else if (land) begin
            valid_q <= 1'b1;
            if (valid_q && !audio_output.ready && ovr_cnt != 16'hFFFF) begin
                ovr_cnt <= ovr_cnt + 16'd1;
            end
        end else if (valid_q && audio_output.ready) begin
            valid_q <= 1'b0;
        end
    end

    assign audio_output.valid = valid_q;
    assign pitch_input.ready  = rdy;
    assign overrun_count      = ovr_cnt;

endmodule
